// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, abort codes, default timing and command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    localparam logic [1:0] ERR_NONE          = 2'd0;
    localparam logic [1:0] ERR_START_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_BIT_TIMEOUT   = 2'd2;
    localparam logic [1:0] ERR_NACK          = 2'd3;

    localparam int DEF_INHIBIT_CYCLES       = 6000;
    localparam int DEF_START_TIMEOUT_CYCLES = 750000;
    localparam int DEF_BIT_TIMEOUT_CYCLES   = 100000;
    localparam int DEF_FILTER_LEN           = 8;

    // Wide enough for the largest timeout (750000 < 2**20)
    localparam int CNT_W = 20;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_DISABLE = 8'hF5;

    // Bits shifted out after the start bit: {stop, odd parity, d7..d0}
    function automatic logic [9:0] frameWord(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and PS/2 pin bundle between a command source and ps2_host_tx.
interface ps2_host_tx_if;
    import ps2_pkg::*;

    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] error_code;

    modport master (
        output cmd_valid, cmd_data, ps2_clk_in, ps2_dat_in,
        input  cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error, error_code
    );

    modport slave (
        input  cmd_valid, cmd_data, ps2_clk_in, ps2_dat_in,
        output cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error, error_code
    );

endinterface

// File: rtl/ps2_line_sync.sv
// PS/2 pin synchronizers and device-clock falling-edge detector, shared with the mouse receiver.
// Define PS2_TX_GLITCH_FILTER_EN to debounce the clock over FILTER_LEN samples before edge detection.
module ps2_line_sync
    import ps2_pkg::*;
#(
`ifdef PS2_TX_GLITCH_FILTER_EN
    parameter int FILTER_LEN = DEF_FILTER_LEN
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic clk_in_i,
    input  logic dat_in_i,
    output logic clk_sync_o,
    output logic dat_sync_o,
    output logic fe_o
);

    logic [1:0] clkSync_q;
    logic [1:0] datSync_q;
    logic       clkPrev_q;
    logic       clkLevel;

    // Idle bus level is high, so reset to 1 to avoid a spurious edge after reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clkSync_q <= 2'b11;
            datSync_q <= 2'b11;
            clkPrev_q <= 1'b1;
        end else begin
            clkSync_q <= {clkSync_q[0], clk_in_i};
            datSync_q <= {datSync_q[0], dat_in_i};
            clkPrev_q <= clkLevel;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [FW-1:0] filtCnt_q, filtCnt_d;
    logic          filt_q, filt_d;

    always_comb begin
        filt_d    = filt_q;
        filtCnt_d = '0;
        if (clkSync_q[1] != filt_q) begin
            if (filtCnt_q >= FW'(FILTER_LEN - 1)) begin
                filt_d = clkSync_q[1];
            end else begin
                filtCnt_d = filtCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_q    <= 1'b1;
            filtCnt_q <= '0;
        end else begin
            filt_q    <= filt_d;
            filtCnt_q <= filtCnt_d;
        end
    end

    assign clkLevel = filt_q;
`else
    assign clkLevel = clkSync_q[1];
`endif

    assign clk_sync_o = clkLevel;
    assign dat_sync_o = datSync_q[1];
    assign fe_o       = clkPrev_q & ~clkLevel;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10 device-clocked bits, ACK check.
// Build option PS2_TX_GLITCH_FILTER_EN enables the clock debounce in ps2_line_sync.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = DEF_INHIBIT_CYCLES,
    parameter int START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
    parameter int BIT_TIMEOUT_CYCLES   = DEF_BIT_TIMEOUT_CYCLES
`ifdef PS2_TX_GLITCH_FILTER_EN
    , parameter int FILTER_LEN         = DEF_FILTER_LEN
`endif
) (
    input  logic          clock,
    input  logic          reset,
    ps2_host_tx_if.slave  bus
);

    localparam logic [CNT_W-1:0] InhibitLast = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] StartLast   = CNT_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BitLast     = CNT_W'(BIT_TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cntInc;
    logic [3:0]       bitIdx_q, bitIdx_d;
    logic [9:0]       word_q, word_d;
    logic             clkOe_q, clkOe_d;
    logic             datOe_q, datOe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [1:0]       errCode_q, errCode_d;
    logic             abort;
    logic [1:0]       abortCode;
    logic             clkSync, datSync, fe;

    ps2_line_sync
`ifdef PS2_TX_GLITCH_FILTER_EN
        #(.FILTER_LEN(FILTER_LEN))
`endif
        uLineSync (
            .clock      (clock),
            .reset      (reset),
            .clk_in_i   (bus.ps2_clk_in),
            .dat_in_i   (bus.ps2_dat_in),
            .clk_sync_o (clkSync),
            .dat_sync_o (datSync),
            .fe_o       (fe)
        );

    assign cntInc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // A device edge is checked before any timeout so that a coincident edge wins
    always_comb begin
        state_d   = state_q;
        cnt_d     = cntInc;
        bitIdx_d  = bitIdx_q;
        word_d    = word_q;
        clkOe_d   = clkOe_q;
        datOe_d   = datOe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        errCode_d = errCode_q;
        abort     = 1'b0;
        abortCode = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.cmd_valid) begin
                    word_d    = frameWord(bus.cmd_data);
                    errCode_d = ERR_NONE;
                    clkOe_d   = 1'b1;
                    datOe_d   = 1'b0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q >= InhibitLast) begin
                    clkOe_d = 1'b0;
                    datOe_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (fe) begin
                    datOe_d  = ~word_q[0];
                    word_d   = {1'b0, word_q[9:1]};
                    bitIdx_d = 4'd1;
                    cnt_d    = '0;
                    state_d  = ST_SEND;
                end else if (cnt_q >= StartLast) begin
                    abort     = 1'b1;
                    abortCode = ERR_START_TIMEOUT;
                end
            end
            ST_SEND: begin
                if (fe) begin
                    datOe_d  = ~word_q[0];
                    word_d   = {1'b0, word_q[9:1]};
                    bitIdx_d = bitIdx_q + 1'b1;
                    cnt_d    = '0;
                    if (bitIdx_q >= 4'd9) begin
                        state_d = ST_ACK;
                    end
                end else if (cnt_q >= BitLast) begin
                    abort     = 1'b1;
                    abortCode = ERR_BIT_TIMEOUT;
                end
            end
            ST_ACK: begin
                datOe_d = 1'b0;
                if (fe) begin
                    cnt_d = '0;
                    if (!datSync) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        abort     = 1'b1;
                        abortCode = ERR_NACK;
                    end
                end else if (cnt_q >= BitLast) begin
                    abort     = 1'b1;
                    abortCode = ERR_BIT_TIMEOUT;
                end
            end
            ST_WAIT_IDLE: begin
                if (clkSync && datSync) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q >= BitLast) begin
                    abort     = 1'b1;
                    abortCode = ERR_BIT_TIMEOUT;
                end
            end
            default: begin
                clkOe_d = 1'b0;
                datOe_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            clkOe_d   = 1'b0;
            datOe_d   = 1'b0;
            error_d   = 1'b1;
            errCode_d = abortCode;
            state_d   = ST_IDLE;
        end
    end

    // Reset releases both lines at once and suppresses any done/error pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bitIdx_q  <= '0;
            word_q    <= '0;
            clkOe_q   <= 1'b0;
            datOe_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            errCode_q <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitIdx_q  <= bitIdx_d;
            word_q    <= word_d;
            clkOe_q   <= clkOe_d;
            datOe_q   <= datOe_d;
            done_q    <= done_d;
            error_q   <= error_d;
            errCode_q <= errCode_d;
        end
    end

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.ps2_clk_oe = clkOe_q;
    assign bus.ps2_dat_oe = datOe_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.error_code = errCode_q;

endmodule
